// File: rtl/rpc_trx_scheduler.sv
// rpc_trx_scheduler: arbitrates write and read requests toward the RPC DRAM
// command path. Response-buffer space (read words, B slots) is reserved as
// credits at grant time, and a bus-turnaround gap separates direction changes.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no command outstanding; a request may be granted
//   ISSUE | cmd_* presented downstream, held stable until cmd_ready_i
module rpc_trx_scheduler #(
  parameter int BufferDepth  = 4,
  parameter int DramLenWidth = 6,
  parameter int AddrWidth    = 27,
  parameter int TurnCycles   = 2,
  localparam int RBufDepth   = BufferDepth << DramLenWidth,
  localparam int RCredW      = $clog2(RBufDepth) + 1,
  localparam int BCredW      = $clog2(BufferDepth) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [AddrWidth-1:0]    wr_addr_i,
  input  logic [DramLenWidth-1:0] wr_len_i,
  input  logic                    rd_valid_i,
  output logic                    rd_ready_o,
  input  logic [AddrWidth-1:0]    rd_addr_i,
  input  logic [DramLenWidth-1:0] rd_len_i,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  output logic                    cmd_is_write_o,
  output logic [AddrWidth-1:0]    cmd_addr_o,
  output logic [DramLenWidth-1:0] cmd_len_o,
  input  logic                    r_pop_i,
  input  logic                    b_pop_i,
  output logic [RCredW-1:0]       r_credit_o,
  output logic [BCredW-1:0]       b_credit_o,
  output logic                    credit_err_o
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            turn_cnt;
  logic                  last_dir_w;   // direction of the last handshake, 1 = write
  logic                  rr_rd_pref;   // 1 = read wins a tie
  logic [DramLenWidth:0] rd_need;
  logic                  wr_elig, rd_elig, grant_wr, grant_rd, handshake;
  logic [RCredW-1:0]     r_credit_q, r_after, r_credit_d;
  logic [BCredW-1:0]     b_credit_q, b_after, b_credit_d;
  logic                  r_ovf, b_ovf;

  // One bit wider than the length field so len+1 never wraps.
  assign rd_need = {1'b0, rd_len_i} + {{DramLenWidth{1'b0}}, 1'b1};

  // Eligibility, round-robin arbitration and next state.
  always_comb begin
    state_d   = state_q;
    wr_elig   = 1'b0;
    rd_elig   = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        wr_elig  = wr_valid_i && (b_credit_q != '0) && !((turn_cnt != '0) && !last_dir_w);
        rd_elig  = rd_valid_i && (RCredW'(rd_need) <= r_credit_q) &&
                   !((turn_cnt != '0) && last_dir_w);
        grant_rd = rd_elig && (!wr_elig || rr_rd_pref);
        grant_wr = wr_elig && !grant_rd;
        if (grant_wr || grant_rd) state_d = ISSUE;
      end
      ISSUE: begin
        handshake = cmd_ready_i;
        if (cmd_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready pulses are combinational but suppressed while reset is held.
  assign wr_ready_o  = grant_wr && !rst_i;
  assign rd_ready_o  = grant_rd && !rst_i;
  assign cmd_valid_o = (state_q == ISSUE);

  // Credit arithmetic: reserve first, then the pop, which is dropped at max.
  always_comb begin
    r_after    = r_credit_q - (grant_rd ? RCredW'(rd_need) : '0);
    b_after    = b_credit_q - (grant_wr ? BCredW'(1) : '0);
    r_credit_d = r_after;
    b_credit_d = b_after;
    r_ovf      = 1'b0;
    b_ovf      = 1'b0;
    if (r_pop_i) begin
      if (r_after == RCredW'(RBufDepth)) r_ovf = 1'b1;
      else r_credit_d = r_after + RCredW'(1);
    end
    if (b_pop_i) begin
      if (b_after == BCredW'(BufferDepth)) b_ovf = 1'b1;
      else b_credit_d = b_after + BCredW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Turnaround counter, last handshake direction and tie-break pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      turn_cnt   <= '0;
      last_dir_w <= 1'b1;
      rr_rd_pref <= 1'b1;
    end else begin
      if (handshake) begin
        turn_cnt   <= 4'(TurnCycles);
        last_dir_w <= cmd_is_write_o;
      end else if (turn_cnt != '0) begin
        turn_cnt <= turn_cnt - 4'd1;
      end
      if (grant_wr)      rr_rd_pref <= 1'b1;
      else if (grant_rd) rr_rd_pref <= 1'b0;
    end
  end

  // Command register, loaded only at grant so it stays stable through ISSUE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_is_write_o <= 1'b0;
      cmd_addr_o     <= '0;
      cmd_len_o      <= '0;
    end else if (grant_wr || grant_rd) begin
      cmd_is_write_o <= grant_wr;
      cmd_addr_o     <= grant_wr ? wr_addr_i : rd_addr_i;
      cmd_len_o      <= grant_wr ? wr_len_i : rd_len_i;
    end
  end

  // Credit counters and sticky overflow flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_credit_q   <= RCredW'(RBufDepth);
      b_credit_q   <= BCredW'(BufferDepth);
      credit_err_o <= 1'b0;
    end else begin
      r_credit_q   <= r_credit_d;
      b_credit_q   <= b_credit_d;
      credit_err_o <= credit_err_o | r_ovf | b_ovf;
    end
  end

  assign r_credit_o = r_credit_q;
  assign b_credit_o = b_credit_q;

endmodule

// File: tb/tb_rpc_trx_scheduler.sv
// Testbench for rpc_trx_scheduler: directed scenarios plus a randomized run
// against a timestamp-based reference model of the scheduling rules.
module tb_rpc_trx_scheduler;
  localparam int BD  = 4;
  localparam int DLW = 6;
  localparam int AW  = 27;
  localparam int TC  = 2;
  localparam int RBD = BD << DLW;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0]  wr_addr, rd_addr, cmd_addr;
  logic [DLW-1:0] wr_len, rd_len, cmd_len;
  logic           cmd_valid, cmd_ready, cmd_is_write;
  logic           r_pop, b_pop, credit_err;
  logic [8:0]     r_credit;
  logic [2:0]     b_credit;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rpc_trx_scheduler #(
    .BufferDepth(BD), .DramLenWidth(DLW), .AddrWidth(AW), .TurnCycles(TC)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_len_i(wr_len),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr), .rd_len_i(rd_len),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_is_write_o(cmd_is_write),
    .cmd_addr_o(cmd_addr), .cmd_len_o(cmd_len),
    .r_pop_i(r_pop), .b_pop_i(b_pop), .r_credit_o(r_credit), .b_credit_o(b_credit),
    .credit_err_o(credit_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 0; wr_addr = '0; wr_len = '0;
    rd_valid = 0; rd_addr = '0; rd_len = '0;
    cmd_ready = 0; r_pop = 0; b_pop = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; wr_valid = 1; rd_valid = 1; cmd_ready = 1;
    repeat (2) @(posedge clk);
    #2;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got=%0b exp=0", wr_ready); end
    total++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL reset_rd_ready got=%0b exp=0", rd_ready); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid got=%0b exp=0", cmd_valid); end
    total++; if (cmd_is_write !== 1'b0) begin bad++; $display("FAIL reset_cmd_is_write got=%0b exp=0", cmd_is_write); end
    total++; if (cmd_addr !== '0) begin bad++; $display("FAIL reset_cmd_addr got=%0h exp=0", cmd_addr); end
    total++; if (cmd_len !== '0) begin bad++; $display("FAIL reset_cmd_len got=%0d exp=0", cmd_len); end
    total++; if (r_credit !== 9'd256) begin bad++; $display("FAIL reset_r_credit got=%0d exp=256", r_credit); end
    total++; if (b_credit !== 3'd4) begin bad++; $display("FAIL reset_b_credit got=%0d exp=4", b_credit); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_credit_err got=%0b exp=0", credit_err); end
    rst = 0;
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a [3];
    int ng = 0;
    bit exp_rdy, exp_cv;
    for (int i = 0; i < 3; i++) a[i] = AW'($urandom);
    apply_reset();
    cmd_ready = 1;
    for (int c = 0; c < 7; c++) begin
      wr_valid = (ng < 3);
      wr_addr  = a[(ng < 3) ? ng : 0];
      wr_len   = '0;
      #1;
      exp_rdy = (c == 0 || c == 2 || c == 4);
      exp_cv  = (c == 1 || c == 3 || c == 5);
      total++; if (wr_ready !== exp_rdy) begin bad++; $display("FAIL b2b_wr_ready c=%0d got=%0b exp=%0b", c, wr_ready, exp_rdy); end
      total++; if (cmd_valid !== exp_cv) begin bad++; $display("FAIL b2b_cmd_valid c=%0d got=%0b exp=%0b", c, cmd_valid, exp_cv); end
      total++; if (b_credit !== 3'(4 - ng)) begin bad++; $display("FAIL b2b_b_credit c=%0d got=%0d exp=%0d", c, b_credit, 4 - ng); end
      if (exp_cv) begin
        total++; if (cmd_addr !== a[(c - 1) / 2] || cmd_is_write !== 1'b1)
          begin bad++; $display("FAIL b2b_cmd c=%0d got=%0h/%0b exp=%0h/1", c, cmd_addr, cmd_is_write, a[(c - 1) / 2]); end
      end
      if (exp_rdy) ng++;
      tick();
    end
  endtask

  task automatic test_b_stall();
    int ng = 0;
    int np = 0;
    bit exp_rdy;
    apply_reset();
    cmd_ready = 1;
    for (int c = 0; c < 14; c++) begin
      wr_valid = (ng < 5);
      wr_addr  = AW'(c);
      b_pop    = (c == 11);
      #1;
      exp_rdy = (c == 0 || c == 2 || c == 4 || c == 6 || c == 12);
      total++; if (wr_ready !== exp_rdy) begin bad++; $display("FAIL bstall_wr_ready c=%0d got=%0b exp=%0b", c, wr_ready, exp_rdy); end
      total++; if (b_credit !== 3'(4 - ng + np)) begin bad++; $display("FAIL bstall_b_credit c=%0d got=%0d exp=%0d", c, b_credit, 4 - ng + np); end
      if (exp_rdy) ng++;
      if (b_pop) np++;
      tick();
    end
    b_pop = 0;
  endtask

  task automatic test_read_credit();
    int ng = 0;
    int exp_rc = RBD;
    bit exp_rdy;
    apply_reset();
    cmd_ready = 1;
    for (int c = 0; c < 13; c++) begin
      rd_valid = (ng < 5);
      rd_len   = (ng < 4) ? 6'd63 : 6'd0;
      rd_addr  = AW'($urandom);
      r_pop    = (c == 10);
      #1;
      exp_rdy = (c == 0 || c == 2 || c == 4 || c == 6 || c == 11);
      total++; if (rd_ready !== exp_rdy) begin bad++; $display("FAIL rcred_rd_ready c=%0d got=%0b exp=%0b", c, rd_ready, exp_rdy); end
      total++; if (r_credit !== 9'(exp_rc)) begin bad++; $display("FAIL rcred_r_credit c=%0d got=%0d exp=%0d", c, r_credit, exp_rc); end
      if (exp_rdy) begin
        exp_rc -= (ng < 4) ? 64 : 1;
        ng++;
      end
      if (r_pop) exp_rc += 1;
      tick();
    end
    r_pop = 0;
  endtask

  task automatic test_turnaround();
    bit exp_r, exp_w, wp, rp;
    apply_reset();
    wr_valid = 1; wr_addr = AW'($urandom); wr_len = 6'd2;
    #1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL turn_first_wr got=%0b exp=1", wr_ready); end
    tick();
    wr_valid = 0;
    for (int c = 1; c < 6; c++) begin
      rd_valid  = 1; rd_len = 6'd5;
      cmd_ready = (c == 2);
      #1;
      exp_r = (c == 5);
      total++; if (rd_ready !== exp_r) begin bad++; $display("FAIL turn_rd_ready c=%0d got=%0b exp=%0b", c, rd_ready, exp_r); end
      tick();
    end
    apply_reset();
    cmd_ready = 1;
    wp = 0; rp = 0;
    for (int c = 0; c < 14; c++) begin
      if (c % 4 == 0) begin wp = 1; rp = 1; end
      wr_valid = wp; rd_valid = rp; rd_len = '0;
      #1;
      exp_w = (c == 4 || c == 12);
      exp_r = (c == 0 || c == 8);
      total++; if (wr_ready !== exp_w) begin bad++; $display("FAIL rr_wr_ready c=%0d got=%0b exp=%0b", c, wr_ready, exp_w); end
      total++; if (rd_ready !== exp_r) begin bad++; $display("FAIL rr_rd_ready c=%0d got=%0b exp=%0b", c, rd_ready, exp_r); end
      if (exp_w) wp = 0;
      if (exp_r) rp = 0;
      tick();
    end
  endtask

  task automatic test_simultaneous();
    int lens [5] = '{63, 63, 63, 53, 3};
    int ng = 0;
    apply_reset();
    cmd_ready = 1;
    for (int c = 0; c < 10; c++) begin
      rd_valid = (ng < 5);
      rd_len   = DLW'((ng < 5) ? lens[ng] : 0);
      r_pop    = (c == 8);
      #1;
      if (c == 7) begin
        total++; if (r_credit !== 9'd10) begin bad++; $display("FAIL simul_start_credit got=%0d exp=10", r_credit); end
      end
      if (c == 8) begin
        total++; if (rd_ready !== 1'b1) begin bad++; $display("FAIL simul_grant got=%0b exp=1", rd_ready); end
      end
      if (c == 9) begin
        total++; if (r_credit !== 9'd7) begin bad++; $display("FAIL simul_r_credit got=%0d exp=7", r_credit); end
        total++; if (cmd_valid !== 1'b1 || cmd_len !== 6'd3 || cmd_is_write !== 1'b0)
          begin bad++; $display("FAIL simul_cmd got=%0b/%0d/%0b exp=1/3/0", cmd_valid, cmd_len, cmd_is_write); end
      end
      if (c == 0 || c == 2 || c == 4 || c == 6 || c == 8) ng++;
      tick();
    end
    r_pop = 0;
  endtask

  task automatic test_overflow_reset();
    logic [AW-1:0] a;
    apply_reset();
    b_pop = 1; r_pop = 1;
    #1;
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL ovf_err_before got=%0b exp=0", credit_err); end
    tick();
    b_pop = 0; r_pop = 0;
    #1;
    total++; if (b_credit !== 3'd4) begin bad++; $display("FAIL ovf_b_credit got=%0d exp=4", b_credit); end
    total++; if (r_credit !== 9'd256) begin bad++; $display("FAIL ovf_r_credit got=%0d exp=256", r_credit); end
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%0b exp=1", credit_err); end
    tick();
    a = AW'($urandom) | AW'(1);
    wr_valid = 1; wr_addr = a; wr_len = 6'd9; cmd_ready = 0;
    #1;
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL ovf_err_sticky got=%0b exp=1", credit_err); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_pre_grant got=%0b exp=1", wr_ready); end
    tick();
    #1;
    total++; if (cmd_valid !== 1'b1 || cmd_addr !== a) begin bad++; $display("FAIL rst_pre_issue got=%0b/%0h exp=1/%0h", cmd_valid, cmd_addr, a); end
    #2;
    rst = 1;
    #1;
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_cmd_valid got=%0b exp=0", cmd_valid); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%0b exp=0", wr_ready); end
    total++; if (cmd_addr !== '0 || cmd_len !== '0 || cmd_is_write !== 1'b0)
      begin bad++; $display("FAIL rst_cmd_fields got=%0h/%0d/%0b exp=0/0/0", cmd_addr, cmd_len, cmd_is_write); end
    total++; if (b_credit !== 3'd4 || r_credit !== 9'd256)
      begin bad++; $display("FAIL rst_credits got=%0d/%0d exp=4/256", b_credit, r_credit); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", credit_err); end
    tick();
    rst = 0;
    idle_inputs();
    tick();
  endtask

  // Reference model: tracks outstanding command, credit balances and the time
  // of the last handshake; opposite-direction grants need cycle > hs + TC.
  task automatic test_random();
    bit busy = 0, cw = 0, last_hs_w = 1, last_gnt_w = 1;
    logic [AW-1:0]  ca = '0, wa = '0, ra = '0;
    logic [DLW-1:0] cl = '0, wl = '0, rl = '0;
    int mr = RBD, mb = BD, hs_cyc = -100;
    bit wp = 0, rp = 0, w_ok, r_ok, gw, gr;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!wp && $urandom_range(0, 2) == 0) begin
        wp = 1; wa = AW'($urandom); wl = DLW'($urandom_range(0, 63));
      end
      if (!rp && $urandom_range(0, 2) == 0) begin
        rp = 1; ra = AW'($urandom);
        rl = ($urandom_range(0, 3) == 0) ? DLW'($urandom_range(32, 63)) : DLW'($urandom_range(0, 15));
      end
      wr_valid = wp; wr_addr = wa; wr_len = wl;
      rd_valid = rp; rd_addr = ra; rd_len = rl;
      cmd_ready = ($urandom_range(0, 2) != 0);
      b_pop = (mb < BD) && ($urandom_range(0, 2) == 0);
      r_pop = (mr < RBD) && ($urandom_range(0, 1) == 0);
      #1;
      w_ok = !busy && wp && (mb >= 1) && !(!last_hs_w && c <= hs_cyc + TC);
      r_ok = !busy && rp && (int'(rl) + 1 <= mr) && !(last_hs_w && c <= hs_cyc + TC);
      gw = w_ok && !(r_ok && last_gnt_w);
      gr = r_ok && !gw;
      total++; if (wr_ready !== gw) begin bad++; $display("FAIL rand_wr_ready c=%0d got=%0b exp=%0b", c, wr_ready, gw); end
      total++; if (rd_ready !== gr) begin bad++; $display("FAIL rand_rd_ready c=%0d got=%0b exp=%0b", c, rd_ready, gr); end
      total++; if (cmd_valid !== busy) begin bad++; $display("FAIL rand_cmd_valid c=%0d got=%0b exp=%0b", c, cmd_valid, busy); end
      total++; if (r_credit !== 9'(mr) || b_credit !== 3'(mb))
        begin bad++; $display("FAIL rand_credits c=%0d got=%0d/%0d exp=%0d/%0d", c, r_credit, b_credit, mr, mb); end
      total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL rand_err c=%0d got=%0b exp=0", c, credit_err); end
      if (busy) begin
        total++; if (cmd_is_write !== cw || cmd_addr !== ca || cmd_len !== cl)
          begin bad++; $display("FAIL rand_cmd c=%0d got=%0b/%0h/%0d exp=%0b/%0h/%0d", c, cmd_is_write, cmd_addr, cmd_len, cw, ca, cl); end
      end
      if (busy && cmd_ready) begin
        busy = 0; last_hs_w = cw; hs_cyc = c;
      end
      if (gw || gr) begin
        busy = 1; cw = gw; last_gnt_w = gw;
        ca = gw ? wa : ra;
        cl = gw ? wl : rl;
      end
      if (gw) begin mb -= 1; wp = 0; end
      if (gr) begin mr -= int'(rl) + 1; rp = 0; end
      if (b_pop) mb += 1;
      if (r_pop) mr += 1;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_b_stall();
    test_read_credit();
    test_turnaround();
    test_simultaneous();
    test_overflow_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
